uart_tx_engine: RTL
===================

# uart_tx_engine

Line-side UART transmitter with a built-in baud generator and a small byte FIFO. Serializes bytes onto `TxD` in 8N1 format: start bit, 8 data bits LSB first, one stop bit. The CPU serial controller drives it through the same single-cycle start/busy handshake it uses for transmission today. The FIFO buffering lets several CPU writes complete without waiting for the line.

## Interface
- `CLK_FREQ`, default 50_000_000: clk frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- `FIFO_DEPTH`, default 4: byte entries; power of two, ≥2.
- Derived `DIV = CLK_FREQ / BAUD` (integer truncation): cycles per bit, ≥2.

- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `tx_start` in 1: one-cycle push strobe for `tx_data`.
- `tx_data` in 8: byte to enqueue; sampled only when `tx_start`=1.
- `tx_busy` out 1: FIFO full; a push in this cycle is dropped.
- `tx_idle` out 1: FIFO empty and FSM in IDLE; the line is quiet.
- `tx_overflow` out 1: sticky flag, set by a dropped push; cleared only by `rst`.
- `TxD` out 1: serial line, registered, idles high.

## Operation
- Push: `tx_start`=1 and `tx_busy`=0 at a clk edge writes `tx_data` at the FIFO tail and increments the count.
- Dropped push: `tx_start`=1 while `tx_busy`=1 does not change the FIFO and sets `tx_overflow`.
- `tx_busy` = (count == FIFO_DEPTH). `tx_idle` = (count == 0) and (state == IDLE). Both are derived from registered state.
- FSM states: IDLE, START, DATA, STOP. A bit counter (0..7) and a baud counter (0..DIV-1) are used.
- IDLE: `TxD`=1. If count>0, pop the head into the shift register, clear the baud counter and move to START.
- START: `TxD`=0 for DIV cycles, then move to DATA with bit index 0.
- DATA: `TxD`=shift[0] for DIV cycles per bit, shifting right after each bit. After bit 7 completes, move to STOP.
- STOP: `TxD`=1 for DIV cycles. On the last STOP cycle:
  - if count>0, pop and go directly to START, so frames are back-to-back with no idle gap;
  - otherwise go to IDLE.
- Simultaneous push and pop in one cycle: both take effect and the count is unchanged. A push while full is dropped even if a pop happens in the same cycle.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values: `TxD`=1, `tx_busy`=0, `tx_idle`=1, `tx_overflow`=0. FIFO is empty, state is IDLE, all counters are 0.
- Reset mid-frame: at the next edge `TxD`=1 and FIFO contents are discarded. The partial frame is truncated with no stop bit.
- Latency from an idle engine: push sampled at edge E0; pop happens at E1; `TxD` falls at E1.
- Frame length is exactly 10×DIV cycles.
- `tx_idle` rises in the cycle after the last STOP cycle when the FIFO is empty.
- `tx_busy` changes one edge after the push or pop that causes it.
- `tx_data` may change freely when `tx_start`=0.

## Structure
- Package `uart_pkg` holds:
  - the state enum `uart_tx_state_t` (IDLE, START, DATA, STOP);
  - `UART_DATA_BITS = 8`;
  - a constant function `uart_div(clk_freq, baud)`, shared with the future receiver rework.
- Sub-module `uart_tx_fifo`: synchronous FIFO with push, pop, `rd_data` (head, combinational), `count`, `full`, `empty`.
- The FSM, baud counter and `TxD` register live in `uart_tx_engine`.

## Test plan
All scenarios use CLK_FREQ=16, BAUD=1, so DIV=16.
- Single byte: push 0x55 while idle -> `TxD` shows 0,1,0,1,0,1,0,1,0,1, 16 cycles each, starting at E1; `tx_idle`=1 at cycle 161.
- Back-to-back: push 0xA5 and 0x3C on consecutive cycles.
  - Expected: the 0x3C start bit immediately follows the 16-cycle 0xA5 stop bit.
  - Total 320 cycles of line activity.
  - Data bits are 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
- Overflow, FIFO_DEPTH=4: push 0x01..0x06 on six consecutive cycles.
  - `tx_busy`=1 after the 5th push.
  - 0x06 is dropped and `tx_overflow`=1.
  - 0x01..0x05 are transmitted in order.
- Push during STOP with FIFO empty: push 0x7E on the 3rd STOP cycle -> the next START begins with no IDLE cycle.
- Reset mid-frame: assert `rst` during DATA bit 4 with 2 bytes queued -> next edge `TxD`=1, `tx_idle`=1, `tx_busy`=0. No further frames are sent.
- Reset clears sticky: after an overflow, `rst` -> `tx_overflow`=0. A following push of 0xFF transmits normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame width and the
// baud divisor helper used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int UART_DATA_BITS = 8;

  // Clock cycles per bit period (integer truncation).
  function automatic int uart_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO. The head entry is visible combinationally on
// rd_data so the transmitter can load it in the same cycle it pops.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = UART_DATA_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A push into a full FIFO is dropped even when a pop happens alongside it.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// 8N1 UART transmitter with integrated baud timing and a byte FIFO. TxD is
// registered from the next-state decode so the start bit appears on the same
// edge the FIFO head is popped.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_idle,
  output logic       tx_overflow,
  output logic       TxD
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD);
  localparam int BW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(UART_DATA_BITS);

  uart_tx_state_t state;
  uart_tx_state_t state_nxt;

  logic [BW-1:0] baud_cnt;
  logic [BW-1:0] baud_nxt;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] bit_nxt;
  logic [7:0]    shift;
  logic [7:0]    shift_nxt;
  logic          txd_nxt;
  logic          pop;
  logic          baud_end;
  logic          last_bit;

  logic [AW:0]   fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;

  uart_tx_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (UART_DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (tx_start),
    .pop     (pop),
    .wr_data (tx_data),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign baud_end = (baud_cnt == BW'(DIV - 1));
  assign last_bit = (bit_cnt == CW'(UART_DATA_BITS - 1));

  assign tx_busy  = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign tx_idle  = (fifo_count == '0) && (state == IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; STOP chains straight into START when bytes are waiting.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = START;
      START:   if (baud_end) state_nxt = DATA;
      DATA:    if (baud_end && last_bit) state_nxt = STOP;
      STOP:    if (baud_end) state_nxt = fifo_empty ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath controls: pop strobe, counters, shift register and line level.
  always_comb begin
    pop       = 1'b0;
    baud_nxt  = baud_cnt + 1'b1;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    case (state)
      IDLE: begin
        baud_nxt = '0;
        bit_nxt  = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_head;
        end
      end
      START: begin
        if (baud_end) begin
          baud_nxt = '0;
          bit_nxt  = '0;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_nxt  = '0;
          bit_nxt   = bit_cnt + 1'b1;
          shift_nxt = shift >> 1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_nxt = '0;
          bit_nxt  = '0;
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_nxt = fifo_head;
          end
        end
      end
      default: baud_nxt = '0;
    endcase
    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = shift_nxt[0];
      default: txd_nxt = 1'b1;
    endcase
  end

  // Control registers, line output and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      TxD         <= 1'b1;
      tx_overflow <= 1'b0;
    end else begin
      baud_cnt    <= baud_nxt;
      bit_cnt     <= bit_nxt;
      TxD         <= txd_nxt;
      tx_overflow <= tx_overflow | (tx_start & fifo_full);
    end
  end

  // Shift register data; holds no meaning outside a frame, so it is not reset.
  always_ff @(posedge clk) begin
    shift <= shift_nxt;
  end

endmodule
